switch_input_reader: RTL and testbench

- Input-side companion to the simple processor's display path: turns the raw input switches and a load push-button into clean, debounced two-byte commands (opcode, operand).
- Commands go to the processor over a valid/ready handshake.
- Sits between the top-level dedicated input pins and the processor core.
- Provides a phase indicator and a sticky overrun flag for LED/status use.

---
 rtl/tt_io_pkg.sv | 13 +
 rtl/sync_debounce.sv | 47 ++++
 rtl/switch_input_reader.sv | 111 +++++++++++
 tb/tb_switch_input_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tt_io_pkg.sv
// Shared constants and FSM encoding for the switch/button command input path.
package tt_io_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE = 50_000;
  localparam int unsigned CMD_W            = 8;

  typedef enum logic [1:0] {
    WAIT_OP  = 2'd0,
    WAIT_ARG = 2'd1,
    FULL     = 2'd2
  } state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a vector-wide debounce: the whole vector
// must differ from the accepted value for DEBOUNCE_CYCLES cycles to update it.
module sync_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Counter clears on the accepting cycle, so it never exceeds LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= '0;
      cnt <= '0;
    end else if (sync2 != db) begin
      if (cnt == LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/switch_input_reader.sv
// Turns debounced switches plus a load button into (opcode, operand) commands
// delivered over valid/ready, with a phase indicator and sticky overrun flag.
module switch_input_reader
  import tt_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [CMD_W-1:0] sw_raw,
  input  logic             btn_raw,
  input  logic             clr_overrun,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CMD_W-1:0] out_opcode,
  output logic [CMD_W-1:0] out_operand,
  output logic             phase,
  output logic             overrun
);

  logic [CMD_W-1:0] sw_db;
  logic             btn_db;
  logic             btn_db_q;
  logic             press_q;
  logic             take;
  logic             cap_op;
  logic             cap_arg;
  state_t           state;
  state_t           state_n;

  sync_debounce #(
    .WIDTH(CMD_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_sw_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sw_raw),
    .db   (sw_db)
  );

  sync_debounce #(
    .WIDTH(1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_btn_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_raw),
    .db   (btn_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      press_q  <= btn_db & ~btn_db_q;
    end
  end

  assign take = press_q & ena;
  // A press landing on the completing handshake starts the next command.
  assign cap_op  = take & ((state == WAIT_OP) | ((state == FULL) & out_ready));
  assign cap_arg = take & (state == WAIT_ARG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_OP;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_OP:  if (take) state_n = WAIT_ARG;
      WAIT_ARG: if (take) state_n = FULL;
      FULL:     if (out_ready) state_n = take ? WAIT_ARG : WAIT_OP;
      default:  state_n = WAIT_OP;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    phase     = 1'b0;
    unique case (state)
      WAIT_ARG: phase     = 1'b1;
      FULL:     out_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_opcode  <= '0;
      out_operand <= '0;
    end else begin
      if (cap_op)  out_opcode  <= sw_db;
      if (cap_arg) out_operand <= sw_db;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         overrun <= 1'b0;
    else if (take && (state == FULL) && !out_ready)     overrun <= 1'b1;
    else if (clr_overrun)                               overrun <= 1'b0;
  end

endmodule

// File: tb/tb_switch_input_reader.sv
// Scoreboarded bench for switch_input_reader with a short debounce window.
module tb_switch_input_reader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] sw_raw = '0;
  logic       btn_raw = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_opcode;
  logic [7:0] out_operand;
  logic       phase;
  logic       overrun;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] sb_q[$];

  switch_input_reader #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .clr_overrun(clr_overrun),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_opcode (out_opcode),
    .out_operand(out_operand),
    .phase      (phase),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full press: button high for 10 cycles, then released long enough to debounce.
  task automatic press(input logic [7:0] sw);
    sw_raw  = sw;
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(10);
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (!out_valid && n < 200) begin
      tick(1);
      n++;
    end
    if (!out_valid) check_val("valid_timeout", 16'(out_valid), 16'd1);
  endtask

  task automatic compare_head();
    logic [15:0] exp;
    check_val("sb_nonempty", 16'(sb_q.size() != 0), 16'd1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
    check_val("sb_opcode", 16'(out_opcode), 16'(exp[15:8]));
    check_val("sb_operand", 16'(out_operand), 16'(exp[7:0]));
  endtask

  task automatic accept();
    wait_valid();
    compare_head();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_val("acc_valid", 16'(out_valid), 16'd0);
    check_val("acc_phase", 16'(phase), 16'd0);
  endtask

  initial begin
    tick(2);
    check_val("rst_valid", 16'(out_valid), 16'd0);
    check_val("rst_outs", {out_opcode, out_operand}, 16'h0000);
    check_val("rst_phase_ovr", {15'd0, phase | overrun}, 16'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: exact capture latency, then a full command
    sw_raw  = 8'hA5;
    btn_raw = 1'b1;
    tick(DB + 3);
    check_val("lat_before", 16'(phase), 16'd0);
    tick(1);
    check_val("lat_at", 16'(phase), 16'd1);
    tick(2);
    btn_raw = 1'b0;
    tick(10);
    sb_q.push_back({8'hA5, 8'h3C});
    press(8'h3C);
    check_val("t1_valid", 16'(out_valid), 16'd1);
    check_val("t1_phase", 16'(phase), 16'd0);
    accept();

    // 2: short glitches on the button never register
    for (int unsigned i = 0; i < 5; i++) begin
      btn_raw = 1'b1;
      tick(DB - 1);
      btn_raw = 1'b0;
      tick(DB - 1);
    end
    tick(10);
    check_val("glitch_phase", 16'(phase), 16'd0);
    check_val("glitch_valid", 16'(out_valid), 16'd0);

    // 3: press while FULL and not ready -> overrun, data held
    sb_q.push_back({8'h11, 8'h22});
    press(8'h11);
    press(8'h22);
    press(8'h77);
    check_val("ovr_set", 16'(overrun), 16'd1);
    check_val("ovr_data", {out_opcode, out_operand}, 16'h1122);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check_val("ovr_clr", 16'(overrun), 16'd0);
    accept();

    // 4: press captured on the same edge as the handshake
    sb_q.push_back({8'h44, 8'h55});
    press(8'h44);
    press(8'h55);
    sw_raw  = 8'h9E;
    btn_raw = 1'b1;
    tick(DB + 3);
    check_val("coin_valid", 16'(out_valid), 16'd1);
    compare_head();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_val("coin_valid_lo", 16'(out_valid), 16'd0);
    check_val("coin_phase", 16'(phase), 16'd1);
    check_val("coin_opcode", 16'(out_opcode), 16'h009E);
    check_val("coin_ovr", 16'(overrun), 16'd0);
    tick(2);
    btn_raw = 1'b0;
    tick(10);
    sb_q.push_back({8'h9E, 8'h6B});
    press(8'h6B);
    accept();

    // 5: ena low drops presses silently
    ena = 1'b0;
    press(8'hF0);
    check_val("ena_phase", 16'(phase), 16'd0);
    check_val("ena_ovr", 16'(overrun), 16'd0);
    ena = 1'b1;
    press(8'h0F);
    check_val("ena_capture", {7'd0, phase, out_opcode}, 16'h010F);

    // 6: asynchronous reset in WAIT_ARG
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_outs", {out_opcode, out_operand}, 16'h0000);
    check_val("arst_flags", {13'd0, phase, out_valid, overrun}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    sb_q.push_back({8'hC3, 8'h81});
    press(8'hC3);
    press(8'h81);
    accept();
    check_val("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
